dispatch_queue: RTL

//  In-order buffer between the decoder and the per-FU reservation stations. Accepts one

---
 rtl/dispatch_queue_pkg.sv | 32 +++
 rtl/dispatch_queue_if.sv | 26 ++
 rtl/dispatch_queue_pkt_fifo.sv | 61 ++++++
 rtl/dispatch_queue.sv | 108 ++++++++++
 4 files changed

// File: rtl/dispatch_queue_pkg.sv
// Shared decode/dispatch definitions: functional-unit types, the decoded
// instruction packet and the dispatch-queue sequencing states.
package sys_defs;

   typedef enum logic [1:0] {
      FU_ALU  = 2'd0,
      FU_MULT = 2'd1,
      FU_BTU  = 2'd2,
      FU_LSU  = 2'd3
   } FU_TYPE;

   localparam int NUM_FU = 4;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } DISP_STATE;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      FU_TYPE      fu;
      logic [4:0]  dest_reg;
   } DECODED_PACK;

   function automatic logic [NUM_FU-1:0] fu_onehot(input FU_TYPE fu);
      return NUM_FU'(1) << fu;
   endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Decoder-side and reservation-station-side handshake of the dispatch queue.
// The slave view belongs to the queue, the master view to its environment.
interface dispatch_queue_if;
   import sys_defs::*;

   logic                in_valid;
   DECODED_PACK         in_pack;
   logic                in_halt;
   logic                in_illegal;
   logic                in_ready;
   logic                out_valid;
   DECODED_PACK         out_pack;
   logic [NUM_FU-1:0]   out_fu_sel;
   logic [NUM_FU-1:0]   rs_ready;

   modport slave (
      input  in_valid, in_pack, in_halt, in_illegal, rs_ready,
      output in_ready, out_valid, out_pack, out_fu_sel
   );

   modport master (
      output in_valid, in_pack, in_halt, in_illegal, rs_ready,
      input  in_ready, out_valid, out_pack, out_fu_sel
   );

endinterface

// File: rtl/dispatch_queue_pkt_fifo.sv
// Circular buffer of decoded packets with push/pop/clear and occupancy.
// Head data is read straight from storage, so an entry is visible the cycle after its push.
module pkt_fifo
   import sys_defs::*;
#(
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            push,
   input  logic            pop,
   input  logic            clear,
   input  DECODED_PACK     push_pack,
   output DECODED_PACK     head_pack,
   output logic [PTR_W:0]  count,
   output logic            full,
   output logic            empty
);

   DECODED_PACK        mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // Power-of-two depth lets the pointers wrap by natural overflow.
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push && !clear) mem[tail] <= push_pack;
   end

   assign head_pack = mem[head];
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign empty     = (count == '0);

   always_ff @(posedge clock) begin
      if (reset_n && !clear) begin
         assert (!(push && full));
         assert (!(pop && empty));
      end
   end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between decode and the per-FU reservation stations,
// with halt/illegal drain sequencing and flush recovery.
module dispatch_queue
   import sys_defs::*;
#(
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   dispatch_queue_if.slave   dq,
   input  logic              flush,
   output logic [PTR_W:0]    count,
   output logic              halted,
   output logic              err
);

   DISP_STATE     state;
   DISP_STATE     state_nxt;
   logic          err_nxt;
   logic          enq;
   logic          fire;
   logic          clear;
   logic          full;
   logic          empty;
   logic          in_ready;
   logic          out_valid;
   DECODED_PACK   head_pack;

   pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (enq),
      .pop       (fire),
      .clear     (clear),
      .push_pack (dq.in_pack),
      .head_pack (head_pack),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = err;
      in_ready  = 1'b0;
      enq       = 1'b0;
      clear     = 1'b0;
      out_valid = 1'b0;
      fire      = 1'b0;

      case (state)
         RUN: begin
            // Readiness uses pre-dequeue occupancy: a full queue never accepts.
            in_ready = !full;
            enq      = dq.in_valid && !full && !dq.in_halt && !dq.in_illegal && !flush;
            if (flush) begin
               clear   = 1'b1;
               err_nxt = 1'b0;
            end else if (dq.in_valid && (dq.in_halt || dq.in_illegal) && !full) begin
               state_nxt = DRAIN;
               err_nxt   = dq.in_illegal;
            end
         end
         DRAIN: begin
            if (flush) begin
               clear     = 1'b1;
               state_nxt = RUN;
               err_nxt   = 1'b0;
            end else if (empty) begin
               state_nxt = HALTED;
            end
         end
         default: begin
         end
      endcase

      // Strict in-order: only the head may leave, whatever other FUs are ready.
      if (state != HALTED && !empty && !flush) begin
         out_valid = 1'b1;
         fire      = dq.rs_ready[head_pack.fu];
      end
   end

   assign dq.in_ready   = in_ready;
   assign dq.out_valid  = out_valid;
   assign dq.out_pack   = head_pack;
   assign dq.out_fu_sel = out_valid ? fu_onehot(head_pack.fu) : '0;
   assign halted        = (state == HALTED);

   always_ff @(posedge clock) begin
      if (reset_n) begin
         assert (!out_valid || $onehot(dq.out_fu_sel));
         assert (out_valid || (dq.out_fu_sel == '0));
      end
   end

endmodule
